// File: rtl/seq_alu.sv
// Multi-cycle RV32IM ALU: single-cycle ALU/branch ops, iterative multiply/divide, valid/ready on both sides.
// Optional macro SEQ_ALU_FAST_MUL_EN: multiply ops use a combinational multiplier and complete in one cycle.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [4:0]       selector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             branch_taken,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out, r_hi, r_lo, r_b;
    logic             r_br, r_out_valid, r_busy, r_is_div, r_neg, r_rneg;
    logic [1:0]       r_fn;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept, w_iter, w_br, w_lt_s, w_lt_u;
    logic             w_a_signed, w_b_signed, w_sign_a, w_sign_b, w_b_zero, w_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res, w_mag_a, w_mag_b, w_min;

    assign in_ready     = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept     = in_valid && in_ready;
    assign out          = r_out;
    assign branch_taken = r_br;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;

    assign w_shamt    = dataB[SHW-1:0];
    assign w_lt_s     = $signed(dataA) < $signed(dataB);
    assign w_lt_u     = dataA < dataB;
    assign w_a_signed = selector inside {5'd17, 5'd18, 5'd20, 5'd22};
    assign w_b_signed = selector inside {5'd17, 5'd20, 5'd22};
    assign w_sign_a   = w_a_signed && dataA[WIDTH-1];
    assign w_sign_b   = w_b_signed && dataB[WIDTH-1];
    assign w_mag_a    = w_sign_a ? -dataA : dataA;
    assign w_mag_b    = w_sign_b ? -dataB : dataB;
    assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_b_zero   = (dataB == '0);
    assign w_ovf      = (dataA == w_min) && (dataB == '1);

`ifdef SEQ_ALU_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] w_fa, w_fb, w_fp;
    assign w_fa = {{WIDTH{w_sign_a}}, dataA};
    assign w_fb = {{WIDTH{w_sign_b}}, dataB};
    assign w_fp = w_fa * w_fb;
`endif

    always_comb begin
        w_res  = '0;
        w_br   = 1'b0;
        w_iter = 1'b0;
        case (selector)
            5'd0:  w_res = dataA + dataB;
            5'd1:  w_res = dataA << w_shamt;
            5'd2:  w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
            5'd3:  w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
            5'd4:  w_res = dataA ^ dataB;
            5'd5:  w_res = dataA >> w_shamt;
            5'd6:  w_res = dataA | dataB;
            5'd7:  w_res = dataA & dataB;
            5'd8:  w_res = dataA - dataB;
            5'd9:  w_res = $signed(dataA) >>> w_shamt;
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
                case (selector[2:0])
                    3'd2:    w_br = (dataA == dataB);
                    3'd3:    w_br = (dataA != dataB);
                    3'd4:    w_br = w_lt_s;
                    3'd5:    w_br = !w_lt_s;
                    3'd6:    w_br = w_lt_u;
                    default: w_br = !w_lt_u;
                endcase
                w_res = {{(WIDTH-1){1'b0}}, w_br};
            end
            5'd16, 5'd17, 5'd18, 5'd19: begin
`ifdef SEQ_ALU_FAST_MUL_EN
                w_res = (selector[1:0] == 2'd0) ? w_fp[WIDTH-1:0] : w_fp[2*WIDTH-1:WIDTH];
`else
                w_iter = 1'b1;
`endif
            end
            5'd20: begin
                if (w_b_zero)  w_res = '1;
                else if (w_ovf) w_res = dataA;
                else           w_iter = 1'b1;
            end
            5'd21: begin
                if (w_b_zero) w_res = '1;
                else          w_iter = 1'b1;
            end
            5'd22: begin
                if (w_b_zero)  w_res = dataA;
                else if (w_ovf) w_res = '0;
                else           w_iter = 1'b1;
            end
            5'd23: begin
                if (w_b_zero) w_res = dataA;
                else          w_iter = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    // One radix-2 step; r_hi/r_lo hold accumulator/multiplier or remainder/quotient.
    logic [WIDTH:0]     w_msum, w_dsh;
    logic               w_dge;
    logic [WIDTH-1:0]   w_ddif, w_hi_n, w_lo_n, w_quo, w_rem, w_fin;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_dsh  = {r_hi, r_lo[WIDTH-1]};
        w_dge  = w_dsh >= {1'b0, r_b};
        w_ddif = w_dsh[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_hi_n = w_dge ? w_ddif : w_dsh[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_dge};
        end else begin
            w_hi_n = w_msum[WIDTH:1];
            w_lo_n = {w_msum[0], r_lo[WIDTH-1:1]};
        end
        w_prod = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
        w_quo  = r_neg ? -w_lo_n : w_lo_n;
        w_rem  = r_rneg ? -w_hi_n : w_hi_n;
        if (r_is_div)
            w_fin = r_fn[1] ? w_rem : w_quo;
        else
            w_fin = (r_fn == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_br        <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_fn        <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_out       <= w_fin;
                        r_br        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_hi        <= '0;
                            r_lo        <= w_mag_a;
                            r_b         <= w_mag_b;
                            r_is_div    <= selector[2];
                            r_fn        <= selector[1:0];
                            r_neg       <= w_sign_a ^ w_sign_b;
                            r_rneg      <= w_sign_a;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_BUSY;
                        end else begin
                            r_out       <= w_res;
                            r_br        <= w_br;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: arithmetic reference model plus directed literal vectors.
module tb_seq_alu;
    localparam int W = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, branch_taken, busy;
    logic [W-1:0] dataA, dataB, out;
    logic [4:0]   selector;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .selector(selector),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .branch_taken(branch_taken), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: RISC-V semantics with 64-bit arithmetic.
    function automatic void model(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic br, output int lat);
        longint sa, sb, q;
        logic [63:0] p;
        logic [4:0] sh;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        br = 1'b0;
        lat = 1;
        r = '0;
        case (sel)
            0:  r = a + b;
            1:  r = a << sh;
            2:  r = (sa < sb) ? 1 : 0;
            3:  r = (a < b) ? 1 : 0;
            4:  r = a ^ b;
            5:  r = a >> sh;
            6:  r = a | b;
            7:  r = a & b;
            8:  r = a - b;
            9:  r = $signed(a) >>> sh;
            10: br = (a == b);
            11: br = (a != b);
            12: br = (sa < sb);
            13: br = (sa >= sb);
            14: br = (a < b);
            15: br = (a >= b);
            16, 17, 18, 19: begin
                if (sel == 19)      p = {32'd0, a} * {32'd0, b};
                else if (sel == 18) p = sa * longint'({32'd0, b});
                else                p = sa * sb;
                r = (sel == 16) ? p[31:0] : p[63:32];
                lat = ML;
            end
            20: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin q = sa / sb; r = q[31:0]; lat = W + 1; end
            end
            21: begin
                if (b == 0) r = '1;
                else begin r = a / b; lat = W + 1; end
            end
            22: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin q = sa % sb; r = q[31:0]; lat = W + 1; end
            end
            23: begin
                if (b == 0) r = a;
                else begin r = a % b; lat = W + 1; end
            end
            default: r = '0;
        endcase
        if (sel >= 10 && sel <= 15) r = {31'd0, br};
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic         br;
        int           rdy;
        bit           iter;
    } exp_t;
    exp_t q[$];

    // Per-cycle compare against the model; inputs change at posedge+1, so negedge sees settled values.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit ex, ev;
            ex = (q.size() > 0);
            ev = ex && (cyc >= q[0].rdy);
            check("out_valid", out_valid, ev);
            check("busy", busy, ex && q[0].iter && (cyc < q[0].rdy));
            check("in_ready", in_ready, !ex || (ev && out_ready));
            if (ev && out_valid) begin
                check("out", out, q[0].res);
                check("branch_taken", branch_taken, q[0].br);
            end
            if (ex && out_valid && out_ready) void'(q.pop_front());
            if (in_valid && in_ready) begin
                exp_t e;
                int lat;
                model(selector, dataA, dataB, e.res, e.br, lat);
                e.rdy = cyc + lat;
                e.iter = (lat > 1);
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1; selector = sel; dataA = a; dataB = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 200);
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; dataA = $urandom; dataB = $urandom; selector = 5'($urandom);
    endtask

    task automatic wait_result(output logic [W-1:0] r, output logic br, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("result_timeout", 0, 1);
        r = out;
        br = branch_taken;
    endtask

    task automatic run(input string name, input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input logic exp_br, input int exp_lat);
        logic [W-1:0] r;
        logic br;
        int lat;
        issue(sel, a, b);
        wait_result(r, br, lat);
        check(name, r, exp);
        check({name, "_br"}, br, exp_br);
        check({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic [W-1:0] r;
        logic br;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dataA = '0; dataB = '0; selector = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_br", branch_taken, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
        run("blt", 5'd12, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1);
        run("bltu", 5'd14, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
        run("bgeu", 5'd15, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 1);
        run("sra", 5'd9, 32'h8000_0000, 32'h4, 32'hF800_0000, 0, 1);
        run("sll", 5'd1, 32'h1, 32'h3F, 32'h8000_0000, 0, 1);
        run("sub", 5'd8, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1);
        run("rsvd", 5'd27, 32'h1234, 32'h5678, 32'h0, 0, 1);
        run("mulh", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, ML);
        run("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, ML);
        run("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 0, ML);
        run("mul", 5'd16, 32'd6, 32'd7, 32'd42, 0, ML);
        run("mul_neg", 5'd16, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0, ML);
        run("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, W + 1);
        run("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, W + 1);
        run("divu", 5'd21, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0, W + 1);
        run("remu", 5'd23, 32'd7, 32'd3, 32'd1, 0, W + 1);
        run("divu_by0", 5'd21, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 1);
        run("rem_by0", 5'd22, 32'd100, 32'd0, 32'd100, 0, 1);
        run("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
        run("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1);

        // Backpressure: result held while out_ready is low, then consume and accept together.
        @(posedge clk); #1 out_ready = 1'b0;
        issue(5'd0, 32'd10, 32'd20);
        wait_result(r, br, lat);
        check("bp_first", r, 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", out, 32'd30);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; selector = 5'd4; dataA = 32'hF0F0; dataB = 32'hFF00;
        @(negedge clk);
        check("bp_accept_rdy", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_result(r, br, lat);
        check("bp_next", r, 32'h0FF0);
        check("bp_next_lat", lat, 1);

        // Back-to-back single-cycle ops at one per cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; selector = 5'd0; dataA = 32'(i); dataB = 32'd100;
            @(negedge clk);
            check("b2b_ready", in_ready, 1);
            if (i > 0) check("b2b_out", out, 32'(i - 1 + 100));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last", out, 32'd103);

        // Reset mid-divide.
        issue(5'd21, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 check("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out", out, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        run("post_rst_add", 5'd0, 32'd2, 32'd3, 32'd5, 0, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
